// File: rtl/fc_accel_pkg.sv
// Shared types and default sizing for the FC accelerator memory path.
package fc_accel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } seq_state_t;

  localparam int ADDRESS_BITS_DEF = 6;
  localparam int COLS_MAC_DEF     = 4;
  localparam int INPUTS_MAC_DEF   = 6;

endpackage

// File: rtl/fc_addr_gen.sv
// Combinational lane-address fan-out: addr[i] = base + idx*STRIDE + i, modulo 2^AW.
module fc_addr_gen #(
  parameter int AW     = 6,
  parameter int N      = 4,
  parameter int STRIDE = 4
) (
  input  logic [AW-1:0]        base,
  input  logic [AW-1:0]        idx,
  output logic [N-1:0][AW-1:0] addr
);

  logic [2*AW-1:0] prod;

  assign prod = {{AW{1'b0}}, idx} * (2*AW)'(STRIDE);

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign addr[i] = AW'({{AW{1'b0}}, base} + prod + (2*AW)'(i));
  end

endmodule

// File: rtl/fc_mem_sequencer.sv
// Layer sequencer: walks ifmap chunks per output group, marks MAC first/last,
// waits out the MAC latency and writes each group's results back to memory.
module fc_mem_sequencer
  import fc_accel_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
  parameter int COLS_MAC     = COLS_MAC_DEF,
  parameter int INPUTS_MAC   = INPUTS_MAC_DEF,
  parameter int MAC_LATENCY  = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [ADDRESS_BITS-1:0]                 if_base,
  input  logic [ADDRESS_BITS-1:0]                 of_base,
  input  logic [ADDRESS_BITS-1:0]                 n_chunks,
  input  logic [ADDRESS_BITS-1:0]                 n_groups,
  output logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0] if_address,
  output logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]   of_w_address,
  output logic [COLS_MAC-1:0][7:0]                of_write,
  output logic [COLS_MAC-1:0]                     en_w,
  output logic                                    mac_in_valid,
  output logic                                    mac_first,
  output logic                                    mac_last,
  output logic [ADDRESS_BITS-1:0]                 chunk_idx,
  output logic [ADDRESS_BITS-1:0]                 group_idx,
  input  logic [COLS_MAC-1:0][7:0]                mac_result,
  output logic                                    busy,
  output logic                                    done
);

  localparam int DCNT_W = $clog2(MAC_LATENCY + 1);
  localparam logic [DCNT_W-1:0] DRAIN_INIT = DCNT_W'(MAC_LATENCY - 1);
  localparam logic [ADDRESS_BITS-1:0] ONE = ADDRESS_BITS'(1);

  seq_state_t state, state_nx;
  logic [ADDRESS_BITS-1:0] c, c_nx, g, g_nx;
  logic [DCNT_W-1:0]       dcnt, dcnt_nx;
  logic                    accept;

  logic [ADDRESS_BITS-1:0] if_base_q, of_base_q, nch_q, ngr_q;

  logic                    vld_p1, first_p1, last_p1;
  logic [ADDRESS_BITS-1:0] chunk_p1;

  logic [INPUTS_MAC-1:0][ADDRESS_BITS-1:0] if_addr_raw;
  logic [COLS_MAC-1:0][ADDRESS_BITS-1:0]   of_addr_raw;

  logic in_fetch, in_write, last_chunk;

  assign in_fetch   = (state == S_FETCH);
  assign in_write   = (state == S_WRITE);
  assign last_chunk = (c == nch_q - ONE);

  always_comb begin
    state_nx = state;
    c_nx     = c;
    g_nx     = g;
    dcnt_nx  = dcnt;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          c_nx     = '0;
          g_nx     = '0;
          state_nx = (n_chunks == '0 || n_groups == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (last_chunk) begin
          state_nx = S_DRAIN;
          dcnt_nx  = DRAIN_INIT;
        end else begin
          c_nx = c + ONE;
        end
      end
      S_DRAIN: begin
        if (dcnt == '0) state_nx = S_WRITE;
        else            dcnt_nx  = dcnt - DCNT_W'(1);
      end
      S_WRITE: begin
        if (g == ngr_q - ONE) begin
          state_nx = S_DONE;
        end else begin
          g_nx     = g + ONE;
          c_nx     = '0;
          state_nx = S_FETCH;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      c     <= '0;
      g     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      c     <= c_nx;
      g     <= g_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // Descriptor latch: data only, sampled at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      if_base_q <= if_base;
      of_base_q <= of_base;
      nch_q     <= n_chunks;
      ngr_q     <= n_groups;
    end
  end

  // Stage p1: MAC sideband aligned with the 1-cycle memory read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      chunk_p1 <= '0;
    end else begin
      vld_p1   <= in_fetch;
      first_p1 <= in_fetch && (c == '0);
      last_p1  <= in_fetch && last_chunk;
      chunk_p1 <= in_fetch ? c : '0;
    end
  end

  fc_addr_gen #(.AW(ADDRESS_BITS), .N(INPUTS_MAC), .STRIDE(INPUTS_MAC)) u_if_addr (
    .base (if_base_q),
    .idx  (c),
    .addr (if_addr_raw)
  );

  fc_addr_gen #(.AW(ADDRESS_BITS), .N(COLS_MAC), .STRIDE(COLS_MAC)) u_of_addr (
    .base (of_base_q),
    .idx  (g),
    .addr (of_addr_raw)
  );

  // Write strobes drop in the reset cycle itself so an aborted WRITE never lands.
  assign if_address   = in_fetch ? if_addr_raw : '0;
  assign of_w_address = in_write ? of_addr_raw : '0;
  assign of_write     = in_write ? mac_result : '0;
  assign en_w         = {COLS_MAC{in_write && !rst}};
  assign mac_in_valid = vld_p1;
  assign mac_first    = first_p1;
  assign mac_last     = last_p1;
  assign chunk_idx    = chunk_p1;
  assign group_idx    = g;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE) && !rst;

endmodule

// File: tb/tb_fc_mem_sequencer.sv
// Directed bench for fc_mem_sequencer with hand-computed expectations.
module tb_fc_mem_sequencer;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [5:0]        if_base, of_base, n_chunks, n_groups;
  logic [5:0][5:0]   if_address;
  logic [3:0][5:0]   of_w_address;
  logic [3:0][7:0]   of_write;
  logic [3:0]        en_w;
  logic              mac_in_valid, mac_first, mac_last;
  logic [5:0]        chunk_idx, group_idx;
  logic [3:0][7:0]   mac_result;
  logic              busy, done;

  int checks = 0;
  int failures = 0;

  fc_mem_sequencer #(.MAC_LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .if_base      (if_base),
    .of_base      (of_base),
    .n_chunks     (n_chunks),
    .n_groups     (n_groups),
    .if_address   (if_address),
    .of_w_address (of_w_address),
    .of_write     (of_write),
    .en_w         (en_w),
    .mac_in_valid (mac_in_valid),
    .mac_first    (mac_first),
    .mac_last     (mac_last),
    .chunk_idx    (chunk_idx),
    .group_idx    (group_idx),
    .mac_result   (mac_result),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] if_exp(input logic [5:0] base);
    logic [35:0] r;
    for (int i = 0; i < 6; i++) r[i*6 +: 6] = base + 6'(i);
    return r;
  endfunction

  function automatic logic [23:0] of_exp(input logic [5:0] base);
    logic [23:0] r;
    for (int i = 0; i < 4; i++) r[i*6 +: 6] = base + 6'(i);
    return r;
  endfunction

  task automatic launch(input logic [5:0] ib, input logic [5:0] ob,
                        input logic [5:0] nc, input logic [5:0] ng);
    if_base = ib; of_base = ob; n_chunks = nc; n_groups = ng;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Basic layer: if_base 0, of_base 32, 2 chunks, 1 group. poke: start in cycle 3.
  task automatic run_basic(input bit poke);
    launch(6'd0, 6'd32, 6'd2, 6'd1);
    check("b_c1_ifaddr", if_address, if_exp(6'd0));
    check("b_c1_busy", busy, 1'b1);
    check("b_c1_vld", mac_in_valid, 1'b0);
    tick();
    check("b_c2_ifaddr", if_address, if_exp(6'd6));
    check("b_c2_sideband", {mac_in_valid, mac_first, mac_last}, 3'b110);
    check("b_c2_chunk", chunk_idx, 6'd0);
    tick();
    if (poke) begin
      if_base = 6'd40; of_base = 6'd8; n_chunks = 6'd5; n_groups = 6'd3;
      start = 1'b1;
    end
    check("b_c3_sideband", {mac_in_valid, mac_first, mac_last}, 3'b101);
    check("b_c3_chunk", chunk_idx, 6'd1);
    check("b_c3_ifaddr", if_address, 36'd0);
    tick();
    start = 1'b0;
    check("b_c4_vld", mac_in_valid, 1'b0);
    check("b_c4_enw", en_w, 4'h0);
    tick();
    check("b_c5_enw", en_w, 4'hF);
    check("b_c5_ofaddr", of_w_address, of_exp(6'd32));
    check("b_c5_ofwrite", of_write, 32'hA1B2C3D4);
    check("b_c5_done", done, 1'b0);
    tick();
    check("b_c6_done", done, 1'b1);
    check("b_c6_busy", busy, 1'b1);
    check("b_c6_enw", en_w, 4'h0);
    tick();
    check("b_c7_done", done, 1'b0);
    check("b_c7_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    if_base = '0; of_base = '0; n_chunks = '0; n_groups = '0;
    mac_result = 32'hA1B2C3D4;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_enw", en_w, 4'h0);
    check("rst_ifaddr", if_address, 36'd0);
    check("rst_ofaddr", of_w_address, 24'd0);
    check("rst_ofwrite", of_write, 32'd0);
    check("rst_side", {mac_in_valid, mac_first, mac_last}, 3'b000);
    check("rst_idx", {chunk_idx, group_idx}, 12'd0);
    tick();
    rst = 1'b0;
    tick();

    run_basic(1'b0);
    tick();

    // Wrap-around
    launch(6'd60, 6'd62, 6'd1, 6'd1);
    check("w_c1_ifaddr", if_address, {6'd1, 6'd0, 6'd63, 6'd62, 6'd61, 6'd60});
    tick();
    check("w_c2_sideband", {mac_in_valid, mac_first, mac_last}, 3'b111);
    tick();
    tick();
    check("w_c4_enw", en_w, 4'hF);
    check("w_c4_ofaddr", of_w_address, {6'd1, 6'd0, 6'd63, 6'd62});
    tick();
    check("w_c5_done", done, 1'b1);
    tick();
    tick();

    // Multi-group: writes in cycles 4, 8, 12; done in 13
    launch(6'd0, 6'd0, 6'd1, 6'd3);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (cyc % 4 == 0) begin
        check("m_enw", en_w, 4'hF);
        check("m_ofaddr", of_w_address, of_exp(6'(cyc - 4)));
        check("m_group", group_idx, 6'(cyc / 4 - 1));
      end else begin
        check("m_enw_idle", en_w, 4'h0);
      end
      check("m_done", done, cyc == 13);
      if (cyc != 13) tick();
    end
    tick();
    check("m_after_busy", busy, 1'b0);
    tick();

    // Zero-size: n_groups=0, then n_chunks=0
    launch(6'd0, 6'd0, 6'd2, 6'd0);
    check("z1_done", done, 1'b1);
    check("z1_enw", en_w, 4'h0);
    tick();
    check("z1_c2", {done, mac_in_valid, busy}, 3'b000);
    tick();
    launch(6'd0, 6'd0, 6'd0, 6'd2);
    check("z2_done", done, 1'b1);
    check("z2_enw", en_w, 4'h0);
    tick();
    check("z2_c2", {done, mac_in_valid, busy}, 3'b000);
    tick();

    // Start while busy
    run_basic(1'b1);
    tick();

    // Reset during WRITE
    launch(6'd0, 6'd32, 6'd2, 6'd1);
    tick(); tick(); tick();
    tick();
    rst = 1'b1;
    #1;
    check("r_c5_enw", en_w, 4'h0);
    check("r_c5_done", done, 1'b0);
    tick();
    rst = 1'b0;
    check("r_c6_busy", busy, 1'b0);
    check("r_c6_done", done, 1'b0);
    tick();
    check("r_c7_done", done, 1'b0);
    check("r_c7_enw", en_w, 4'h0);
    run_basic(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
